// File: rtl/ps2_envio_trama.sv
// ---------------------------------------------------------------------------
// ps2_envio_trama
//
// Serialises one byte as an 11-bit PS/2-style frame
//   {stop=1, parity, dato[7:0] (LSB first on the line), start=0}
// and advances one frame bit per bit-time pulse from the upstream
// bit-timer. After the stop bit, the next bit-time pulse returns the line
// to idle. On that same pulse the device acknowledge is sampled from the
// synchronised line readback.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   tiempo     one-cycle bit-time pulse
//   inicio     frame start request (level, honoured only when idle)
//   dato       byte to send, captured when the request is accepted
//   linea_rx   serial line readback (asynchronous to clk)
//   serie      registered serial output, idle high
//   ocupado    high while a frame is in progress
//   listo      one-cycle frame-complete pulse
//   error_ack  1 = device did not acknowledge the last frame
//   n_bit      index of the frame bit on serie (0..10), 0 when idle
// ---------------------------------------------------------------------------
module ps2_envio_trama #(
  parameter bit PARIDAD_IMPAR = 1'b1   // 1 = odd parity, 0 = even parity
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tiempo,
  input  logic       inicio,
  input  logic [7:0] dato,
  input  logic       linea_rx,
  output logic       serie,
  output logic       ocupado,
  output logic       listo,
  output logic       error_ack,
  output logic [3:0] n_bit
);

  // ACK is the last frame bit (stop) on the line: the next bit time
  // samples the acknowledge and closes the frame.
  typedef enum logic [2:0] {
    IDLE,
    ESPERA,
    ENVIO,
    ACK,
    FIN
  } estado_t;

  estado_t     estado, estado_sig;
  logic        cargar;      // accept request, capture byte
  logic        desplazar;   // put the next frame bit on the line
  logic        muestrear;   // sample the acknowledge, release the line
  logic [10:0] trama;       // remaining frame bits, next one in bit 0
  logic        paridad;
  logic        sinc1, sinc2;

  assign paridad = PARIDAD_IMPAR ? ~^dato : ^dato;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) estado <= IDLE;
    else      estado <= estado_sig;
  end

  // ---------------------------------------------------------------------
  // Next state and control strobes
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // can leave one unassigned and infer a latch.
    estado_sig = estado;
    cargar     = 1'b0;
    desplazar  = 1'b0;
    muestrear  = 1'b0;
    unique case (estado)
      // A tiempo in the acceptance cycle is deliberately not a bit time.
      IDLE: begin
        if (inicio) begin
          cargar     = 1'b1;
          estado_sig = ESPERA;
        end
      end
      ESPERA: begin
        if (tiempo) begin
          desplazar  = 1'b1;
          estado_sig = ENVIO;
        end
      end
      ENVIO: begin
        if (tiempo) begin
          desplazar = 1'b1;
          // Bit 9 is on the line now; this pulse puts the stop bit out.
          if (n_bit == 4'd9) estado_sig = ACK;
        end
      end
      ACK: begin
        if (tiempo) begin
          muestrear  = 1'b1;
          estado_sig = FIN;
        end
      end
      FIN:     estado_sig = IDLE;
      default: estado_sig = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Frame shifter, serial output, bit index and acknowledge flag
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trama     <= '1;
      serie     <= 1'b1;
      n_bit     <= 4'd0;
      error_ack <= 1'b0;
    end else begin
      if (cargar) begin
        trama     <= {1'b1, paridad, dato, 1'b0};
        error_ack <= 1'b0;
      end
      if (desplazar) begin
        serie <= trama[0];
        trama <= {1'b1, trama[10:1]};
        n_bit <= (estado == ESPERA) ? 4'd0 : n_bit + 4'd1;
      end
      if (muestrear) begin
        serie     <= 1'b1;
        error_ack <= sinc2;   // a low line means the device acknowledged
        n_bit     <= 4'd0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Two-flop synchroniser for the line readback, idles high
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sinc1 <= 1'b1;
      sinc2 <= 1'b1;
    end else begin
      sinc1 <= linea_rx;
      sinc2 <= sinc1;
    end
  end

  assign ocupado = (estado == ESPERA) || (estado == ENVIO) || (estado == ACK);
  assign listo   = (estado == FIN);

endmodule

// File: tb/tb_ps2_envio_trama.sv
// ---------------------------------------------------------------------------
// Testbench for ps2_envio_trama. Two instances (odd and even parity) share
// the same stimulus. A frame-level model tracks the number of bit times
// since acceptance and derives every output from it, and a compare process
// checks both instances on every falling edge. Directed frames pin the
// model with hand-computed literal frames.
// ---------------------------------------------------------------------------
module tb_ps2_envio_trama;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tiempo = 1'b0;
  logic       inicio = 1'b0;
  logic [7:0] dato = 8'h00;
  logic       linea_rx = 1'b1;

  logic       serie_i, ocupado_i, listo_i, error_ack_i;
  logic [3:0] n_bit_i;
  logic       serie_p, ocupado_p, listo_p, error_ack_p;
  logic [3:0] n_bit_p;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ps2_envio_trama #(.PARIDAD_IMPAR(1'b1)) dut_impar (
    .clk(clk), .rst(rst), .tiempo(tiempo), .inicio(inicio), .dato(dato),
    .linea_rx(linea_rx), .serie(serie_i), .ocupado(ocupado_i),
    .listo(listo_i), .error_ack(error_ack_i), .n_bit(n_bit_i)
  );

  ps2_envio_trama #(.PARIDAD_IMPAR(1'b0)) dut_par (
    .clk(clk), .rst(rst), .tiempo(tiempo), .inicio(inicio), .dato(dato),
    .linea_rx(linea_rx), .serie(serie_p), .ocupado(ocupado_p),
    .listo(listo_p), .error_ack(error_ack_p), .n_bit(n_bit_p)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: frame as an 11-bit word, progress as a count of
  // bit times since acceptance (0..11 while busy).
  // ---------------------------------------------------------------------
  function automatic logic [10:0] build_frame(input logic [7:0] d, input bit odd);
    int  ones = 0;
    logic par;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    par = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
    return {1'b1, par, d, 1'b0};
  endfunction

  bit          m_busy = 1'b0, m_fin = 1'b0, m_err = 1'b0;
  int          m_k = 0;
  logic [10:0] m_fr_i = '1, m_fr_p = '1;
  logic        lr_h1 = 1'b1, lr_h2 = 1'b1;   // linea_rx one and two edges back

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_fin <= 1'b0; m_err <= 1'b0; m_k <= 0;
      lr_h1  <= 1'b1; lr_h2 <= 1'b1;
    end else begin
      lr_h1 <= linea_rx;
      lr_h2 <= lr_h1;
      if (m_fin) m_fin <= 1'b0;
      else if (!m_busy) begin
        if (inicio) begin
          m_busy <= 1'b1; m_k <= 0; m_err <= 1'b0;
          m_fr_i <= build_frame(dato, 1'b1);
          m_fr_p <= build_frame(dato, 1'b0);
        end
      end else if (tiempo) begin
        if (m_k == 11) begin
          m_busy <= 1'b0; m_fin <= 1'b1; m_err <= lr_h2; m_k <= 0;
        end else m_k <= m_k + 1;
      end
    end
  end

  function automatic logic exp_serie(input logic [10:0] fr, input bit busy, input int k);
    return (busy && k >= 1) ? fr[k-1] : 1'b1;
  endfunction

  function automatic logic [3:0] exp_nbit(input bit busy, input int k);
    return (busy && k >= 1) ? 4'(k - 1) : 4'd0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("serie_impar",   serie_i,     exp_serie(m_fr_i, m_busy, m_k));
      check("serie_par",     serie_p,     exp_serie(m_fr_p, m_busy, m_k));
      check("n_bit_impar",   n_bit_i,     exp_nbit(m_busy, m_k));
      check("n_bit_par",     n_bit_p,     exp_nbit(m_busy, m_k));
      check("ocupado_impar", ocupado_i,   m_busy);
      check("ocupado_par",   ocupado_p,   m_busy);
      check("listo_impar",   listo_i,     m_fin);
      check("listo_par",     listo_p,     m_fin);
      check("err_impar",     error_ack_i, m_err);
      check("err_par",       error_ack_p, m_err);
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  int          listo_cnt;
  logic [10:0] cap_i, cap_p;
  logic        err_fin;

  task automatic step();
    @(posedge clk);
    #1;
    if (listo_i) listo_cnt++;
  endtask

  // Sends one frame with random gaps between bit times. Captures the bit on
  // serie after each of the first 11 bit times. Optionally: tiempo together
  // with inicio, a second inicio mid-frame, or a reset after bit time abort_at.
  task automatic send_frame(input logic [7:0] d, input logic lr, input bit same_t,
                            input bit mid_ini, input int abort_at);
    listo_cnt = 0;
    cap_i = '0; cap_p = '0;
    linea_rx = lr; dato = d; inicio = 1'b1; tiempo = same_t;
    step();
    inicio = 1'b0; tiempo = 1'b0; dato = ~d;
    for (int k = 1; k <= 12; k++) begin
      repeat ($urandom_range(0, 3)) step();
      if (mid_ini && k == 4) begin
        inicio = 1'b1; dato = 8'hFF;
        step();
        inicio = 1'b0;
      end
      tiempo = 1'b1;
      step();
      tiempo = 1'b0;
      if (k <= 11) begin
        cap_i[k-1] = serie_i;
        cap_p[k-1] = serie_p;
      end
      if (k == abort_at) begin
        rst = 1'b0;
        #1;
        check("abort_serie",   serie_i,   1'b1);
        check("abort_ocupado", ocupado_i, 1'b0);
        check("abort_nbit",    n_bit_i,   4'd0);
        repeat (3) step();
        rst = 1'b1;
        return;
      end
      if (k == 12) begin
        check("listo_on_12th", listo_i, 1'b1);
        err_fin = error_ack_i;
      end else if (k == 11) begin
        check("no_listo_before_12th", listo_cnt, 0);
      end
    end
    step();
  endtask

  // ---------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------
  initial begin
    #12;
    check("rst_serie",   serie_i,     1'b1);
    check("rst_ocupado", ocupado_i,   1'b0);
    check("rst_listo",   listo_i,     1'b0);
    check("rst_err",     error_ack_i, 1'b0);
    check("rst_nbit",    n_bit_i,     4'd0);
    chk_en = 1'b1;
    step();
    rst = 1'b1;
    repeat (2) step();

    // 0xA5, odd parity, acknowledged
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 0);
    check("seq_A5",       cap_i,     11'b11101001010);
    check("listo_cnt_A5", listo_cnt, 1);
    check("err_A5",       err_fin,   1'b0);

    // 0x01, odd parity, not acknowledged
    send_frame(8'h01, 1'b1, 1'b0, 1'b0, 0);
    check("seq_01",       cap_i,     11'b10000000010);
    check("listo_cnt_01", listo_cnt, 1);
    check("err_01",       err_fin,   1'b1);
    check("err_held",     error_ack_i, 1'b1);

    // 0x00 on both parities
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 0);
    check("seq_00_even", cap_p, 11'b10000000000);
    check("seq_00_odd",  cap_i, 11'b11000000000);

    // second inicio during the frame is ignored
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 0);
    check("seq_5A",       cap_i,     11'b11010110100);
    check("listo_cnt_5A", listo_cnt, 1);

    // inicio and tiempo in the same idle cycle
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 0);
    check("seq_C3",       cap_i,     11'b11110000110);
    check("listo_cnt_C3", listo_cnt, 1);

    // reset after the 5th bit time, then a clean frame
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 5);
    check("listo_cnt_abort", listo_cnt, 0);
    step();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0);
    check("seq_3C",       cap_i,     11'b11001111000);
    check("listo_cnt_3C", listo_cnt, 1);

    // inicio held high: back-to-back frames
    inicio = 1'b1;
    for (int c = 0; c < 400; c++) begin
      tiempo = ($urandom_range(0, 1) == 0);
      dato = 8'($urandom);
      step();
    end
    inicio = 1'b0; tiempo = 1'b0;

    // fully random traffic, including line noise and rare resets
    for (int c = 0; c < 3000; c++) begin
      inicio = ($urandom_range(0, 5) == 0);
      tiempo = ($urandom_range(0, 2) == 0);
      dato   = 8'($urandom);
      if ($urandom_range(0, 3) == 0) linea_rx = 1'($urandom);
      if ($urandom_range(0, 699) == 0) begin
        rst = 1'b0;
        step();
        rst = 1'b1;
      end
      step();
    end
    inicio = 1'b0; tiempo = 1'b0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
